unsigned_multiplier_arbiter: RTL

Sequencing and arbitration controller that shares one internal `Unsigned_Array_Multiplier_16_Bit` instance between `NUM_REQ` requesters. Each requester presents a valid/ready operand pair. The block grants one requester at a time (round-robin by default), registers the operands, drives the multiplier enable for exactly one evaluation cycle and registers the 32-bit product. It then returns the product with the requester ID over a valid/ready response channel. It sits between the multiplier datapath and the client blocks that need multiplication.

---
 rtl/unsigned_multiplier_arbiter.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/unsigned_multiplier_arbiter.sv
// Arbitrated front end sharing one 16x16 unsigned multiplier between NUM_REQ requesters.
// Define MULT_ARB_FIXED_PRIORITY_EN for lowest-index-wins arbitration instead of round-robin.

module Unsigned_Array_Multiplier_16_Bit (
  input  logic        Enable_In,
  input  logic [15:0] A_In,
  input  logic [15:0] B_In,
  output wire  [31:0] Product_Out
);

  assign Product_Out = Enable_In ? ({16'b0, A_In} * {16'b0, B_In}) : 32'bz;

endmodule

module unsigned_multiplier_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = 2
) (
  input  logic                    Clock_In,
  input  logic                    Reset_N_In,
  input  logic [NUM_REQ-1:0]      Req_Valid_In,
  output logic [NUM_REQ-1:0]      Req_Ready_Out,
  input  logic [16*NUM_REQ-1:0]   Req_Data_A_In,
  input  logic [16*NUM_REQ-1:0]   Req_Data_B_In,
  output logic                    Resp_Valid_Out,
  input  logic                    Resp_Ready_In,
  output logic [ID_WIDTH-1:0]     Resp_Id_Out,
  output logic [31:0]             Resp_Result_Out,
  output logic                    Busy_Out
);

  typedef enum logic [1:0] {IDLE, MULT, RESP} state_e;

  state_e                state_q, state_d;
  logic [15:0]           opA_q, opB_q;
  logic [ID_WIDTH-1:0]   id_q;
  logic [ID_WIDTH-1:0]   respId_q;
  logic [31:0]           result_q;

  logic                  grantValid;
  logic [ID_WIDTH-1:0]   grantId;
  logic [15:0]           selA, selB;
  logic                  mulEnable;
  wire  [31:0]           mulProduct;

`ifdef MULT_ARB_FIXED_PRIORITY_EN
  always_comb begin
    grantValid = 1'b0;
    grantId    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (Req_Valid_In[i]) begin
        grantValid = 1'b1;
        grantId    = ID_WIDTH'(i);
      end
    end
  end
`else
  localparam logic [ID_WIDTH:0] SUM_N = (ID_WIDTH + 1)'(NUM_REQ);

  logic [ID_WIDTH-1:0]   rrPtr_q, rrPtr_d;
  logic [ID_WIDTH:0]     candSum;

  // Scan downward in offset from the pointer so the closest valid requester wins.
  always_comb begin
    grantValid = 1'b0;
    grantId    = '0;
    candSum    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      candSum = {1'b0, rrPtr_q} + (ID_WIDTH + 1)'(i);
      if (candSum >= SUM_N) candSum = candSum - SUM_N;
      if (Req_Valid_In[candSum[ID_WIDTH-1:0]]) begin
        grantValid = 1'b1;
        grantId    = candSum[ID_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    rrPtr_d = rrPtr_q;
    if (state_q == IDLE && grantValid) begin
      rrPtr_d = (grantId == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grantId + 1'b1;
    end
  end

  always_ff @(posedge Clock_In or negedge Reset_N_In) begin
    if (!Reset_N_In) rrPtr_q <= '0;
    else             rrPtr_q <= rrPtr_d;
  end
`endif

  always_comb begin
    selA = '0;
    selB = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grantId == ID_WIDTH'(i)) begin
        selA = Req_Data_A_In[16*i +: 16];
        selB = Req_Data_B_In[16*i +: 16];
      end
    end
  end

  Unsigned_Array_Multiplier_16_Bit u_mult (
    .Enable_In   (mulEnable),
    .A_In        (opA_q),
    .B_In        (opB_q),
    .Product_Out (mulProduct)
  );

  // Ready is gated by reset so an asserted reset silences the grant even while in IDLE.
  always_comb begin
    state_d        = state_q;
    Req_Ready_Out  = '0;
    mulEnable      = 1'b0;
    Resp_Valid_Out = 1'b0;
    Busy_Out       = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (grantValid && Reset_N_In) begin
          Req_Ready_Out = NUM_REQ'(1) << grantId;
          state_d       = MULT;
        end
      end
      MULT: begin
        mulEnable = 1'b1;
        state_d   = RESP;
      end
      RESP: begin
        Resp_Valid_Out = 1'b1;
        if (Resp_Ready_In) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock_In or negedge Reset_N_In) begin
    if (!Reset_N_In) begin
      state_q  <= IDLE;
      opA_q    <= '0;
      opB_q    <= '0;
      id_q     <= '0;
      result_q <= '0;
      respId_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && grantValid) begin
        opA_q <= selA;
        opB_q <= selB;
        id_q  <= grantId;
      end
      if (state_q == MULT) begin
        result_q <= mulProduct;
        respId_q <= id_q;
      end
    end
  end

  assign Resp_Result_Out = result_q;
  assign Resp_Id_Out     = respId_q;

endmodule
